// File: rtl/c2c_pkg.sv
// Shared types and helpers for the core-to-cache write path.
package c2c_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } c2c_arb_state_t;

    function automatic int unsigned C2C_SEL_W(input int unsigned xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/c2c_w.sv
// Core-to-cache write link: master holds we/payload until a one-cycle ack.
interface c2c_w
    import c2c_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    localparam int unsigned SEL_W = C2C_SEL_W(XLEN);

    logic             we;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic             ack;

    modport master (output we, sel, addr, data, input ack);
    modport slave  (input we, sel, addr, data, output ack);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, cyclically.
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req_vec,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int unsigned W = $clog2(N);

    int unsigned  idx;
    logic [W-1:0] idx_w;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // explicit wrap keeps non-power-of-2 N correct
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (!gnt_valid && req_vec[idx_w]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_w;
            end
        end
    end

endmodule

// File: rtl/c2c_w_arb.sv
// Round-robin arbiter sharing one c2c_w cache write port among NREQ requesters.
module c2c_w_arb
    import c2c_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREQ = 2
) (
    input  logic clk,
    input  logic rst,
    c2c_w.slave  req [NREQ],
    c2c_w.master mem
);

    localparam int unsigned SEL_W = C2C_SEL_W(XLEN);
    localparam int unsigned IDX_W = $clog2(NREQ);

    c2c_arb_state_t   state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;

    logic [NREQ-1:0]  we_vec;
    logic [SEL_W-1:0] sel_arr  [NREQ];
    logic [XLEN-1:0]  addr_arr [NREQ];
    logic [XLEN-1:0]  data_arr [NREQ];

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign we_vec[i]   = req[i].we;
        assign sel_arr[i]  = req[i].sel;
        assign addr_arr[i] = req[i].addr;
        assign data_arr[i] = req[i].data;
        // ack is a combinational pass-through to the current winner only
        assign req[i].ack  = (state_q == BUSY) && !rst && mem.ack && (gnt_q == IDX_W'(i));
    end

    rr_pick #(
        .N (NREQ)
    ) u_pick (
        .req_vec   (we_vec),
        .ptr       (rr_q),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    gnt_d   = pick_idx;
                    sel_d   = sel_arr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    data_d  = data_arr[pick_idx];
                    rr_d    = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            BUSY: begin
                if (mem.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem.we   = (state_q == BUSY);
    assign mem.sel  = sel_q;
    assign mem.addr = addr_q;
    assign mem.data = data_q;

endmodule
